// File: rtl/updown_pkg.sv
// Shared constants for the up/down counter: run-time mode codes and direction encoding.
package updown_pkg;

  localparam logic [1:0] MODE_UP     = 2'b00;
  localparam logic [1:0] MODE_DOWN   = 2'b01;
  localparam logic [1:0] MODE_BOUNCE = 2'b10;
  localparam logic [1:0] MODE_HOLD   = 2'b11;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  typedef enum logic {
    ST_DOWN = DIR_DOWN,
    ST_UP   = DIR_UP
  } dir_state_e;

endpackage

// File: rtl/updown_counter_n_if.sv
// Control/status bundle of the up/down counter: enable, mode, load in; count, direction, terminal count out.
interface updown_counter_n_if #(
  parameter int WIDTH = 4
);
  logic             En;
  logic [1:0]       Mode;
  logic             Load;
  logic [WIDTH-1:0] Load_val;
  logic [WIDTH-1:0] Count;
  logic             Dir;
  logic             Tc;

  modport master (output En, Mode, Load, Load_val, input Count, Dir, Tc);
  modport slave  (input En, Mode, Load, Load_val, output Count, Dir, Tc);
endinterface

// File: rtl/updown_dir_ctrl.sv
// Direction FSM and limit compare: produces the registered direction, the next count and the wrap/turnaround flag.
module updown_dir_ctrl
  import updown_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter int MAX_COUNT = 2**WIDTH-1,
  parameter int SATURATE  = 0
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_load,
  input  logic             i_en,
  input  logic [1:0]       i_mode,
  input  logic [WIDTH-1:0] i_count,
  output logic             o_dir,
  output logic [WIDTH-1:0] o_count_nxt,
  output logic             o_limit
);

  localparam logic [WIDTH-1:0] LIM    = WIDTH'(MAX_COUNT);
  localparam logic [WIDTH-1:0] LIM_M1 = WIDTH'(MAX_COUNT - 1);
  localparam logic [WIDTH-1:0] ONE    = WIDTH'(1);

  dir_state_e r_state;
  dir_state_e w_state_nxt;
  logic       w_at_max;
  logic       w_at_zero;

  assign w_at_max  = (i_count == LIM);
  assign w_at_zero = (i_count == '0);
  assign o_dir     = r_state;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= ST_UP;
    else          r_state <= w_state_nxt;
  end

  // Load only retargets the direction; the loaded count itself is muxed in the parent.
  always_comb begin
    w_state_nxt = r_state;
    o_count_nxt = i_count;
    o_limit     = 1'b0;
    if (i_load) begin
      if (i_mode == MODE_UP)        w_state_nxt = ST_UP;
      else if (i_mode == MODE_DOWN) w_state_nxt = ST_DOWN;
    end else if (i_en) begin
      case (i_mode)
        MODE_UP: begin
          w_state_nxt = ST_UP;
          if (SATURATE != 0) begin
            if (!w_at_max) begin
              o_count_nxt = i_count + ONE;
              o_limit     = (i_count == LIM_M1);
            end
          end else if (w_at_max) begin
            o_count_nxt = '0;
            o_limit     = 1'b1;
          end else begin
            o_count_nxt = i_count + ONE;
          end
        end
        MODE_DOWN: begin
          w_state_nxt = ST_DOWN;
          if (SATURATE != 0) begin
            if (!w_at_zero) begin
              o_count_nxt = i_count - ONE;
              o_limit     = (i_count == ONE);
            end
          end else if (w_at_zero) begin
            o_count_nxt = LIM;
            o_limit     = 1'b1;
          end else begin
            o_count_nxt = i_count - ONE;
          end
        end
        MODE_BOUNCE: begin
          // Endpoints are visited once: turning around steps straight off the limit.
          if (r_state == ST_UP) begin
            if (w_at_max) begin
              o_count_nxt = LIM_M1;
              w_state_nxt = ST_DOWN;
              o_limit     = 1'b1;
            end else begin
              o_count_nxt = i_count + ONE;
            end
          end else begin
            if (w_at_zero) begin
              o_count_nxt = ONE;
              w_state_nxt = ST_UP;
              o_limit     = 1'b1;
            end else begin
              o_count_nxt = i_count - ONE;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/updown_counter_n.sv
// Synchronous up/down/bounce counter with load clamp, wrap or saturate, and a registered terminal-count pulse.
module updown_counter_n
  import updown_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter int MAX_COUNT = 2**WIDTH-1,
  parameter int SATURATE  = 0
) (
  input  logic              CLK,
  input  logic              Reset_n,
  updown_counter_n_if.slave bus
);

  localparam logic [WIDTH-1:0] LIM = WIDTH'(MAX_COUNT);

  logic [WIDTH-1:0] r_count;
  logic             r_tc;
  logic [WIDTH-1:0] w_count_nxt;
  logic [WIDTH-1:0] w_load_clamp;
  logic             w_limit;
  logic             w_dir;

  updown_dir_ctrl #(
    .WIDTH     (WIDTH),
    .MAX_COUNT (MAX_COUNT),
    .SATURATE  (SATURATE)
  ) u_dir_ctrl (
    .i_clk       (CLK),
    .i_rst_n     (Reset_n),
    .i_load      (bus.Load),
    .i_en        (bus.En),
    .i_mode      (bus.Mode),
    .i_count     (r_count),
    .o_dir       (w_dir),
    .o_count_nxt (w_count_nxt),
    .o_limit     (w_limit)
  );

  // Out-of-range load values clamp to the limit so Count can never exceed it.
  assign w_load_clamp = (bus.Load_val > LIM) ? LIM : bus.Load_val;

  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) begin
      r_count <= '0;
      r_tc    <= 1'b0;
    end else if (bus.Load) begin
      r_count <= w_load_clamp;
      r_tc    <= 1'b0;
    end else begin
      r_count <= w_count_nxt;
      r_tc    <= w_limit;
    end
  end

  assign bus.Count = r_count;
  assign bus.Dir   = w_dir;
  assign bus.Tc    = r_tc;

endmodule

// File: tb/tb_updown_counter_n.sv
// Bench for updown_counter_n: four configurations driven in lockstep, directed scenarios plus random traffic vs a reference model.
module tb_updown_counter_n;

  localparam int MAXC [4] = '{15, 15, 3, 9};
  localparam int SATC [4] = '{0, 1, 0, 0};

  logic       CLK = 1'b0;
  logic       Reset_n = 1'b1;
  logic       tb_en = 1'b0;
  logic [1:0] tb_mode = 2'b00;
  logic       tb_load = 1'b0;
  logic [3:0] tb_lv = 4'd0;

  int n_vec = 0;
  int n_err = 0;
  int m_cnt [4];
  int m_dir [4];
  int m_tc  [4];

  logic [3:0] o_cnt [4];
  logic       o_dir [4];
  logic       o_tc  [4];

  always #5 CLK = ~CLK;

  updown_counter_n_if #(.WIDTH(4)) if0 ();
  updown_counter_n_if #(.WIDTH(4)) if1 ();
  updown_counter_n_if #(.WIDTH(4)) if2 ();
  updown_counter_n_if #(.WIDTH(4)) if3 ();

  updown_counter_n #(.WIDTH(4), .MAX_COUNT(15), .SATURATE(0)) u0 (.CLK(CLK), .Reset_n(Reset_n), .bus(if0.slave));
  updown_counter_n #(.WIDTH(4), .MAX_COUNT(15), .SATURATE(1)) u1 (.CLK(CLK), .Reset_n(Reset_n), .bus(if1.slave));
  updown_counter_n #(.WIDTH(4), .MAX_COUNT(3),  .SATURATE(0)) u2 (.CLK(CLK), .Reset_n(Reset_n), .bus(if2.slave));
  updown_counter_n #(.WIDTH(4), .MAX_COUNT(9),  .SATURATE(0)) u3 (.CLK(CLK), .Reset_n(Reset_n), .bus(if3.slave));

  assign if0.En = tb_en;  assign if0.Mode = tb_mode;  assign if0.Load = tb_load;  assign if0.Load_val = tb_lv;
  assign if1.En = tb_en;  assign if1.Mode = tb_mode;  assign if1.Load = tb_load;  assign if1.Load_val = tb_lv;
  assign if2.En = tb_en;  assign if2.Mode = tb_mode;  assign if2.Load = tb_load;  assign if2.Load_val = tb_lv;
  assign if3.En = tb_en;  assign if3.Mode = tb_mode;  assign if3.Load = tb_load;  assign if3.Load_val = tb_lv;

  assign o_cnt[0] = if0.Count;  assign o_dir[0] = if0.Dir;  assign o_tc[0] = if0.Tc;
  assign o_cnt[1] = if1.Count;  assign o_dir[1] = if1.Dir;  assign o_tc[1] = if1.Tc;
  assign o_cnt[2] = if2.Count;  assign o_dir[2] = if2.Dir;  assign o_tc[2] = if2.Tc;
  assign o_cnt[3] = if3.Count;  assign o_dir[3] = if3.Dir;  assign o_tc[3] = if3.Tc;

  // Behavioural model: one clock edge for configuration k, straight from the counting rules.
  task automatic ref_step(input int k);
    int mx;
    mx = MAXC[k];
    if (tb_load) begin
      m_cnt[k] = (int'(tb_lv) > mx) ? mx : int'(tb_lv);
      m_tc[k]  = 0;
      if (tb_mode == 2'd0)      m_dir[k] = 1;
      else if (tb_mode == 2'd1) m_dir[k] = 0;
    end else if (!tb_en || tb_mode == 2'd3) begin
      m_tc[k] = 0;
    end else if (tb_mode == 2'd0) begin
      m_dir[k] = 1;
      if (SATC[k] != 0) begin
        if (m_cnt[k] == mx) m_tc[k] = 0;
        else begin m_cnt[k] = m_cnt[k] + 1; m_tc[k] = (m_cnt[k] == mx) ? 1 : 0; end
      end else if (m_cnt[k] == mx) begin m_cnt[k] = 0; m_tc[k] = 1; end
      else begin m_cnt[k] = m_cnt[k] + 1; m_tc[k] = 0; end
    end else if (tb_mode == 2'd1) begin
      m_dir[k] = 0;
      if (SATC[k] != 0) begin
        if (m_cnt[k] == 0) m_tc[k] = 0;
        else begin m_cnt[k] = m_cnt[k] - 1; m_tc[k] = (m_cnt[k] == 0) ? 1 : 0; end
      end else if (m_cnt[k] == 0) begin m_cnt[k] = mx; m_tc[k] = 1; end
      else begin m_cnt[k] = m_cnt[k] - 1; m_tc[k] = 0; end
    end else begin
      if (m_dir[k] == 1) begin
        if (m_cnt[k] == mx) begin m_cnt[k] = mx - 1; m_dir[k] = 0; m_tc[k] = 1; end
        else begin m_cnt[k] = m_cnt[k] + 1; m_tc[k] = 0; end
      end else begin
        if (m_cnt[k] == 0) begin m_cnt[k] = 1; m_dir[k] = 1; m_tc[k] = 1; end
        else begin m_cnt[k] = m_cnt[k] - 1; m_tc[k] = 0; end
      end
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 4; k++) begin
      m_cnt[k] = 0; m_dir[k] = 1; m_tc[k] = 0;
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    for (int k = 0; k < 4; k++) ref_step(k);
    #1;
  endtask

  task automatic apply_reset();
    tb_en = 1'b0; tb_mode = 2'b00; tb_load = 1'b0; tb_lv = 4'd0;
    Reset_n = 1'b0;
    #7;
    Reset_n = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    apply_reset();
    n_vec++;
    if (o_cnt[0] !== 4'd0 || o_dir[0] !== 1'b1 || o_tc[0] !== 1'b0) begin
      n_err++; $display("FAIL reset_state: got cnt=%0d dir=%b tc=%b, want 0 1 0", o_cnt[0], o_dir[0], o_tc[0]);
    end
    tb_load = 1'b1; tb_lv = 4'd4; tb_mode = 2'b00;
    tick();
    tb_load = 1'b0; tb_en = 1'b1;
    tick();
    n_vec++;
    if (o_cnt[0] !== 4'd5) begin n_err++; $display("FAIL pre_reset_count: got %0d want 5", o_cnt[0]); end
    #2;
    Reset_n = 1'b0;
    #1;
    model_reset();
    n_vec++;
    if (o_cnt[0] !== 4'd0 || o_dir[0] !== 1'b1 || o_tc[0] !== 1'b0) begin
      n_err++; $display("FAIL async_reset: got cnt=%0d dir=%b tc=%b, want 0 1 0", o_cnt[0], o_dir[0], o_tc[0]);
    end
    @(posedge CLK);
    #1;
    n_vec++;
    if (o_cnt[0] !== 4'd0) begin n_err++; $display("FAIL reset_held: got %0d want 0", o_cnt[0]); end
    Reset_n = 1'b1;
    tick();
    n_vec++;
    if (o_cnt[0] !== 4'd1) begin n_err++; $display("FAIL first_after_release: got %0d want 1", o_cnt[0]); end
  endtask

  task automatic test_up_wrap();
    apply_reset();
    tb_en = 1'b1; tb_mode = 2'b00;
    for (int i = 0; i < 17; i++) begin
      tick();
      n_vec++;
      if (o_cnt[0] !== 4'((i + 1) % 16) || o_tc[0] !== (i == 15) || o_dir[0] !== 1'b1) begin
        n_err++; $display("FAIL up_wrap[%0d]: got cnt=%0d tc=%b dir=%b, want %0d %b 1", i, o_cnt[0], o_tc[0], o_dir[0], (i + 1) % 16, (i == 15));
      end
    end
  endtask

  task automatic test_sat_down();
    int exp_c [4] = '{1, 0, 0, 0};
    bit exp_t [4] = '{0, 1, 0, 0};
    tb_load = 1'b1; tb_lv = 4'd2; tb_mode = 2'b01; tb_en = 1'b1;
    tick();
    tb_load = 1'b0;
    n_vec++;
    if (o_cnt[1] !== 4'd2 || o_dir[1] !== 1'b0 || o_tc[1] !== 1'b0) begin
      n_err++; $display("FAIL sat_load: got cnt=%0d dir=%b tc=%b, want 2 0 0", o_cnt[1], o_dir[1], o_tc[1]);
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      n_vec++;
      if (o_cnt[1] !== 4'(exp_c[i]) || o_tc[1] !== exp_t[i] || o_dir[1] !== 1'b0) begin
        n_err++; $display("FAIL sat_down[%0d]: got cnt=%0d tc=%b dir=%b, want %0d %b 0", i, o_cnt[1], o_tc[1], o_dir[1], exp_c[i], exp_t[i]);
      end
    end
  endtask

  task automatic test_bounce();
    int exp_c [8] = '{1, 2, 3, 2, 1, 0, 1, 2};
    bit exp_d [8] = '{1, 1, 1, 0, 0, 0, 1, 1};
    bit exp_t [8] = '{0, 0, 0, 1, 0, 0, 1, 0};
    apply_reset();
    tb_en = 1'b1; tb_mode = 2'b10;
    for (int i = 0; i < 8; i++) begin
      tick();
      n_vec++;
      if (o_cnt[2] !== 4'(exp_c[i]) || o_dir[2] !== exp_d[i] || o_tc[2] !== exp_t[i]) begin
        n_err++; $display("FAIL bounce[%0d]: got cnt=%0d dir=%b tc=%b, want %0d %b %b", i, o_cnt[2], o_dir[2], o_tc[2], exp_c[i], exp_d[i], exp_t[i]);
      end
    end
  endtask

  task automatic test_load_clamp();
    tb_load = 1'b1; tb_en = 1'b1; tb_mode = 2'b00; tb_lv = 4'd14;
    tick();
    tb_load = 1'b0;
    n_vec++;
    if (o_cnt[3] !== 4'd9 || o_tc[3] !== 1'b0 || o_cnt[0] !== 4'd14) begin
      n_err++; $display("FAIL load_clamp: got m9=%0d tc=%b m15=%0d, want 9 0 14", o_cnt[3], o_tc[3], o_cnt[0]);
    end
    tick();
    n_vec++;
    if (o_cnt[3] !== 4'd0 || o_tc[3] !== 1'b1 || o_cnt[0] !== 4'd15 || o_tc[0] !== 1'b0) begin
      n_err++; $display("FAIL clamp_wrap: got m9=%0d tc=%b m15=%0d tc=%b, want 0 1 15 0", o_cnt[3], o_tc[3], o_cnt[0], o_tc[0]);
    end
  endtask

  task automatic test_idle();
    tb_load = 1'b1; tb_lv = 4'd7; tb_mode = 2'b00; tb_en = 1'b0;
    tick();
    tb_load = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (i == 3) begin tb_mode = 2'b11; tb_en = 1'b1; end
      tick();
      n_vec++;
      if (o_cnt[0] !== 4'd7 || o_tc[0] !== 1'b0 || o_dir[0] !== 1'b1) begin
        n_err++; $display("FAIL idle[%0d]: got cnt=%0d tc=%b dir=%b, want 7 0 1", i, o_cnt[0], o_tc[0], o_dir[0]);
      end
    end
  endtask

  task automatic test_mode_switch();
    tb_load = 1'b1; tb_lv = 4'd6; tb_mode = 2'b00; tb_en = 1'b1;
    tick();
    tb_load = 1'b0; tb_mode = 2'b01;
    for (int i = 0; i < 2; i++) begin
      tick();
      n_vec++;
      if (o_cnt[0] !== 4'(5 - i) || o_dir[0] !== 1'b0 || o_tc[0] !== 1'b0) begin
        n_err++; $display("FAIL mode_switch[%0d]: got cnt=%0d dir=%b tc=%b, want %0d 0 0", i, o_cnt[0], o_dir[0], o_tc[0], 5 - i);
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      tb_en   = ($urandom_range(0, 3) != 0);
      tb_mode = 2'($urandom_range(0, 3));
      tb_load = ($urandom_range(0, 9) == 0);
      tb_lv   = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 63) == 0) begin
        #2;
        Reset_n = 1'b0;
        #1;
        model_reset();
        #1;
        Reset_n = 1'b1;
      end
      tick();
      for (int k = 0; k < 4; k++) begin
        n_vec++;
        if (o_cnt[k] !== 4'(m_cnt[k]) || o_dir[k] !== m_dir[k][0] || o_tc[k] !== m_tc[k][0]) begin
          n_err++; $display("FAIL random[%0d] cfg%0d: got cnt=%0d dir=%b tc=%b, want %0d %0d %0d", i, k, o_cnt[k], o_dir[k], o_tc[k], m_cnt[k], m_dir[k], m_tc[k]);
        end
      end
    end
  endtask

  initial begin
    model_reset();
    #1;
    test_reset();
    test_up_wrap();
    test_sat_down();
    test_bounce();
    test_load_clamp();
    test_idle();
    test_mode_switch();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/updown_counter_n.md
Name: updown_counter_n

Overview:
Parametrised synchronous up/down counter, the successor to the per-bit ripple up and down counters with an external 4-bit select mux.
- All bits switch on one clock edge, so the output never shows ripple glitches.
- Direction is chosen by a run-time mode: up, down, bounce (ping-pong) or hold.
- Adds enable, synchronous parallel load, a programmable terminal value, wrap or saturate selection, and a registered terminal-count pulse.
- Used as the lab timer/sequence source feeding display and test logic.

Parameters:
WIDTH, 4, counter width in bits (>=2)
MAX_COUNT, 2**WIDTH-1, upper count limit; legal range 1..2**WIDTH-1; lower limit is always 0
SATURATE, 0, 0 = wrap at the limits, 1 = stop at the limits (up/down modes only)

Ports:
CLK  input  1  clock; all state updates on the rising edge
Reset_n  input  1  asynchronous active-low reset
En  input  1  count enable; 0 holds Count
Mode  input  2  00 up, 01 down, 10 bounce, 11 hold
Load  input  1  synchronous parallel load strobe
Load_val  input  WIDTH  value loaded when Load=1
Count  output  WIDTH  current count, registered
Dir  output  1  current direction, 1 = up, registered
Tc  output  1  terminal-count pulse, registered, one cycle wide

Behaviour:
- Reset: Reset_n=0 asynchronously forces Count=0, Dir=1, Tc=0 and holds them while low. Reset assertion mid-count aborts the count immediately. The first update after release happens on the first rising CLK edge with Reset_n=1.
- Priority on each edge: Load > En > hold.
- Load:
  - Count <= min(Load_val, MAX_COUNT); Tc <= 0.
  - Dir is set by mode: up mode forces 1, down mode forces 0, bounce and hold leave it unchanged.
  - Load applies regardless of En or Mode.
- Idle: En=0 with no Load, or Mode=11 (hold), freezes Count and Dir; Tc <= 0.
- Up mode (Mode=00), En=1: Dir <= 1.
  - Wrap (SATURATE=0): Count < MAX_COUNT increments with Tc <= 0. Count == MAX_COUNT goes to 0 with Tc <= 1.
  - Saturate (SATURATE=1): Count == MAX_COUNT-1 goes to MAX_COUNT with Tc <= 1. Count == MAX_COUNT holds with Tc <= 0.
- Down mode (Mode=01), En=1: Dir <= 0.
  - Wrap: Count > 0 decrements. Count == 0 goes to MAX_COUNT with Tc <= 1.
  - Saturate: Count == 1 goes to 0 with Tc <= 1. Count == 0 holds with Tc <= 0.
- Bounce mode (Mode=10), En=1: two-state direction FSM, UP (Dir=1) and DOWN (Dir=0). SATURATE is ignored.
  - UP, Count < MAX_COUNT: increment.
  - UP, Count == MAX_COUNT: Count <= MAX_COUNT-1, state -> DOWN, Tc <= 1.
  - DOWN, Count > 0: decrement.
  - DOWN, Count == 0: Count <= 1, state -> UP, Tc <= 1.
  - Endpoints are never repeated. With MAX_COUNT=3 the sequence is 0,1,2,3,2,1,0,1...
- Tc timing: Tc is high for exactly the one cycle following the edge that wrapped, turned around or reached the saturation limit.
- Mode change takes effect on the next edge; Count is never reset by a mode change. Entering bounce keeps the current Dir as the FSM state.
- MAX_COUNT < 2**WIDTH-1 gives a modulo-(MAX_COUNT+1) counter. Count never exceeds MAX_COUNT.
- No combinational path from any input to any output.

Decomposition:
- Shared package updown_pkg holds:
  - mode constants MODE_UP=2'b00, MODE_DOWN=2'b01, MODE_BOUNCE=2'b10, MODE_HOLD=2'b11;
  - direction constants DIR_UP=1, DIR_DOWN=0.
- One sub-module is natural: updown_dir_ctrl. It is the bounce-mode direction FSM plus limit compare, and outputs next Dir and the turnaround/wrap flag.
- The top level holds the Count register, load clamp and Tc register.

Test Plan:
1. Reset_n=0 mid-count at Count=5 -> Count=0, Dir=1, Tc=0 immediately (asynchronous). Then Mode=00, En=1 with WIDTH=4 defaults -> 0,1,...,15,0; Tc high only in the cycle after the 15->0 edge.
2. Mode=01, SATURATE=1, Load_val=2 -> Count 2,1,0,0,0; Tc high one cycle after the 1->0 edge only; Dir=0.
3. Mode=10, MAX_COUNT=3 from reset -> Count 0,1,2,3,2,1,0,1; Dir falls after the 3->2 edge; Tc pulses follow the 3->2 and 0->1 edges.
4. Load=1 and En=1 on the same edge with Load_val=14 and MAX_COUNT=9 -> Count=9 (clamped), Tc=0. Next up edge -> Count=0, Tc=1.
5. En=0 for 3 cycles at Count=7, then Mode=11 with En=1 -> Count stays 7, Tc=0 throughout.
6. Switch Mode 00->01 at Count=6 -> next edges give 5,4; Dir=0 after the first down edge; no Tc.
